// File: rtl/pattern_gen.sv
// Video test-pattern generator: eight frame-synchronous patterns including a bouncing box,
// two-stage pixel pipeline (compares, then colour mux) with DE delayed to match.
module pattern_gen #(
  parameter int COLOR_W    = 8,
  parameter int X_POS_W    = 10,
  parameter int Y_POS_W    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CHECK_LOG2 = 5,
  parameter int RAMP_SHIFT = 2,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  input  logic               de_i,
  input  logic               frame_start_i,
  input  logic [2:0]         mode_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               de_o,
  output logic [15:0]        frame_cnt_o
);

  localparam int XW = X_POS_W + 1;
  localparam int YW = Y_POS_W + 1;
  localparam logic [XW-1:0] BX_MAX  = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic [YW-1:0] BY_MAX  = YW'(V_ACTIVE - BOX_SIZE);
  localparam logic [XW-1:0] STEP_X  = XW'(BOX_STEP);
  localparam logic [YW-1:0] STEP_Y  = YW'(BOX_STEP);
  localparam logic [XW-1:0] SIZE_X  = XW'(BOX_SIZE);
  localparam logic [YW-1:0] SIZE_Y  = YW'(BOX_SIZE);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] DARK = {COLOR_W{1'b1}} >> 2;

  // Frame-level state
  logic [2:0]         mode_q;
  logic [X_POS_W-1:0] bx, bx_nxt;
  logic [Y_POS_W-1:0] by, by_nxt;
  logic               dx_neg, dx_neg_nxt;
  logic               dy_neg, dy_neg_nxt;
  logic [15:0]        frame_cnt;

  // Stage-1 registers
  logic               s1_de;
  logic [2:0]         s1_mode;
  logic [X_POS_W-1:0] s1_x;
  logic               s1_in_box, s1_cross_x, s1_cross_y, s1_check;
  logic [2:0]         s1_bar;

  // Stage-1 combinational compares
  logic [XW-1:0]      bx_ext, x_ext, sum_x;
  logic [YW-1:0]      by_ext, y_ext, sum_y;
  logic               in_box, cross_x, cross_y, check_bit;
  logic [2:0]         bar_idx;

  assign bx_ext = {1'b0, bx};
  assign by_ext = {1'b0, by};
  assign x_ext  = {1'b0, x_i};
  assign y_ext  = {1'b0, y_i};
  assign sum_x  = bx_ext + STEP_X;
  assign sum_y  = by_ext + STEP_Y;

  // Bounce: clamp to the edge and reverse on the frame that would overshoot.
  always_comb begin
    bx_nxt     = bx;
    dx_neg_nxt = dx_neg;
    if (!dx_neg) begin
      if (sum_x > BX_MAX) begin
        bx_nxt     = BX_MAX[X_POS_W-1:0];
        dx_neg_nxt = 1'b1;
      end else begin
        bx_nxt = sum_x[X_POS_W-1:0];
      end
    end else if (bx_ext < STEP_X) begin
      bx_nxt     = '0;
      dx_neg_nxt = 1'b0;
    end else begin
      bx_nxt = bx - X_POS_W'(BOX_STEP);
    end
  end

  always_comb begin
    by_nxt     = by;
    dy_neg_nxt = dy_neg;
    if (!dy_neg) begin
      if (sum_y > BY_MAX) begin
        by_nxt     = BY_MAX[Y_POS_W-1:0];
        dy_neg_nxt = 1'b1;
      end else begin
        by_nxt = sum_y[Y_POS_W-1:0];
      end
    end else if (by_ext < STEP_Y) begin
      by_nxt     = '0;
      dy_neg_nxt = 1'b0;
    end else begin
      by_nxt = by - Y_POS_W'(BOX_STEP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= '0;
      bx        <= '0;
      by        <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_start_i) begin
      mode_q    <= mode_i;
      bx        <= bx_nxt;
      by        <= by_nxt;
      dx_neg    <= dx_neg_nxt;
      dy_neg    <= dy_neg_nxt;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    in_box    = (x_ext >= bx_ext) && (x_ext < bx_ext + SIZE_X) &&
                (y_ext >= by_ext) && (y_ext < by_ext + SIZE_Y);
    cross_x   = (int'(x_i) == H_ACTIVE / 2);
    cross_y   = (int'(y_i) == V_ACTIVE / 2);
    check_bit = x_i[CHECK_LOG2] ^ y_i[CHECK_LOG2];
    bar_idx   = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_i) >= (k * H_ACTIVE) / 8) bar_idx = 3'(k);
    end
    // Off the right edge falls into the black bar.
    if (int'(x_i) >= H_ACTIVE) bar_idx = 3'd7;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_de      <= 1'b0;
      s1_mode    <= '0;
      s1_x       <= '0;
      s1_in_box  <= 1'b0;
      s1_cross_x <= 1'b0;
      s1_cross_y <= 1'b0;
      s1_check   <= 1'b0;
      s1_bar     <= '0;
    end else begin
      s1_de      <= de_i;
      s1_mode    <= mode_q;
      s1_x       <= x_i;
      s1_in_box  <= in_box;
      s1_cross_x <= cross_x;
      s1_cross_y <= cross_y;
      s1_check   <= check_bit;
      s1_bar     <= bar_idx;
    end
  end

  // Stage-2 colour mux
  logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt, ramp;
  logic [2:0]         bar_rgb;

  assign ramp = COLOR_W'(s1_x >> RAMP_SHIFT);

  always_comb begin
    case (s1_bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (s1_de) begin
      case (s1_mode)
        3'd1: begin
          r_nxt = FULL; g_nxt = FULL; b_nxt = FULL;
        end
        3'd2: begin
          r_nxt = {COLOR_W{bar_rgb[2]}};
          g_nxt = {COLOR_W{bar_rgb[1]}};
          b_nxt = {COLOR_W{bar_rgb[0]}};
        end
        3'd3: begin
          r_nxt = {COLOR_W{s1_check}};
          g_nxt = {COLOR_W{s1_check}};
          b_nxt = {COLOR_W{s1_check}};
        end
        3'd4: begin
          r_nxt = ramp; g_nxt = ramp; b_nxt = ramp;
        end
        3'd5: begin
          r_nxt = s1_in_box ? FULL : DARK;
          g_nxt = s1_in_box ? FULL : DARK;
          b_nxt = s1_in_box ? FULL : DARK;
        end
        3'd6: begin
          r_nxt = s1_cross_x ? FULL : ramp;
          g_nxt = ramp;
          b_nxt = s1_cross_y ? FULL : ramp;
        end
        default: begin
          r_nxt = '0; g_nxt = '0; b_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      de_o    <= 1'b0;
    end else begin
      red_o   <= r_nxt;
      green_o <= g_nxt;
      blue_o  <= b_nxt;
      de_o    <= s1_de;
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: an integer-level pattern model feeds a two-deep expected
// pipeline that is checked against the DUT on every falling edge.
module tb_pattern_gen;
  localparam int COLOR_W = 8, X_POS_W = 10, Y_POS_W = 10;
  localparam int H_ACTIVE = 640, V_ACTIVE = 480, CHECK_LOG2 = 5, RAMP_SHIFT = 2;
  localparam int BOX_SIZE = 32, BOX_STEP = 2;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic [X_POS_W-1:0] x_i = '0;
  logic [Y_POS_W-1:0] y_i = '0;
  logic               de_i = 1'b0, frame_start_i = 1'b0;
  logic [2:0]         mode_i = '0;
  logic [COLOR_W-1:0] red_o, green_o, blue_o;
  logic               de_o;
  logic [15:0]        frame_cnt_o;

  pattern_gen dut (
    .clk_i(clk), .rst_ni(rst_ni), .x_i(x_i), .y_i(y_i), .de_i(de_i),
    .frame_start_i(frame_start_i), .mode_i(mode_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .de_o(de_o),
    .frame_cnt_o(frame_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  int m_mode, m_bx, m_by, m_fc;
  bit m_dxn, m_dyn;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] model_pix(int mode, int x, int y, bit de);
    int g;
    g = (x >> RAMP_SHIFT) % 256;
    if (!de) return 24'h0;
    case (mode)
      1: return 24'hFFFFFF;
      2: return (x >= H_ACTIVE) ? 24'h0 : bar_tab[x * 8 / H_ACTIVE];
      3: return ((((x >> CHECK_LOG2) ^ (y >> CHECK_LOG2)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      4: return {g[7:0], g[7:0], g[7:0]};
      5: return (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
                ? 24'hFFFFFF : 24'h3F3F3F;
      6: return {(x == H_ACTIVE / 2) ? 8'hFF : g[7:0], g[7:0],
                 (y == V_ACTIVE / 2) ? 8'hFF : g[7:0]};
      default: return 24'h0;
    endcase
  endfunction

  task automatic model_frame(input int mode);
    m_mode = mode;
    if (!m_dxn) begin
      if (m_bx + BOX_STEP > H_ACTIVE - BOX_SIZE) begin m_bx = H_ACTIVE - BOX_SIZE; m_dxn = 1; end
      else m_bx += BOX_STEP;
    end else begin
      if (m_bx < BOX_STEP) begin m_bx = 0; m_dxn = 0; end
      else m_bx -= BOX_STEP;
    end
    if (!m_dyn) begin
      if (m_by + BOX_STEP > V_ACTIVE - BOX_SIZE) begin m_by = V_ACTIVE - BOX_SIZE; m_dyn = 1; end
      else m_by += BOX_STEP;
    end else begin
      if (m_by < BOX_STEP) begin m_by = 0; m_dyn = 0; end
      else m_by -= BOX_STEP;
    end
    m_fc = (m_fc + 1) % 65536;
  endtask

  // Expected pipeline: p1 = pixel taken at the last edge, p2 = pixel now on the outputs
  logic [23:0] p1 = '0, p2 = '0;
  bit p1v = 0, p2v = 0, p1de = 0, p2de = 0;

  // Driver: inputs change 1 time unit after the active edge
  task automatic step(input int x, input int y, input bit de, input bit fs, input int mode);
    int xm, ym;
    logic [23:0] e;
    xm = x & ((1 << X_POS_W) - 1);
    ym = y & ((1 << Y_POS_W) - 1);
    x_i = xm[X_POS_W-1:0];
    y_i = ym[Y_POS_W-1:0];
    de_i = de;
    frame_start_i = fs;
    mode_i = mode[2:0];
    e = model_pix(m_mode, xm, ym, de);
    @(posedge clk);
    #1;
    if (fs) model_frame(mode);
    p2 = p1; p2v = p1v; p2de = p1de;
    p1 = e;  p1v = 1;   p1de = de;
    frame_start_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    de_i = 1'b0;
    frame_start_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check({tag, "_red"}, 32'(red_o), 32'h0);
    check({tag, "_green"}, 32'(green_o), 32'h0);
    check({tag, "_blue"}, 32'(blue_o), 32'h0);
    check({tag, "_de"}, 32'(de_o), 32'h0);
    check({tag, "_fcnt"}, 32'(frame_cnt_o), 32'h0);
    m_mode = 0; m_bx = 0; m_by = 0; m_dxn = 0; m_dyn = 0; m_fc = 0;
    p1v = 0; p2v = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (rst_ni) begin
      if (p2v) begin
        check("rgb", 32'({red_o, green_o, blue_o}), 32'(p2));
        check("de_o", 32'(de_o), 32'(p2de));
      end
      check("frame_cnt", 32'(frame_cnt_o), 32'(m_fc));
    end
  end

  initial begin
    // Hand-computed pins on the model itself
    m_bx = 0; m_by = 0;
    check("pin_bar_x80", 32'(model_pix(2, 80, 0, 1)), 32'hFFFF00);
    check("pin_bar_x560", 32'(model_pix(2, 560, 0, 1)), 32'h000000);
    check("pin_chk_31_0", 32'(model_pix(3, 31, 0, 1)), 32'h000000);
    check("pin_chk_32_0", 32'(model_pix(3, 32, 0, 1)), 32'hFFFFFF);
    check("pin_chk_32_32", 32'(model_pix(3, 32, 32, 1)), 32'h000000);
    check("pin_ramp_4", 32'(model_pix(4, 4, 0, 1)), 32'h010101);
    check("pin_ramp_1023", 32'(model_pix(4, 1023, 0, 1)), 32'hFFFFFF);
    check("pin_ramp_de0", 32'(model_pix(4, 100, 0, 0)), 32'h000000);
    check("pin_cross", 32'(model_pix(6, 320, 240, 1)), 32'hFF50FF);

    // Reset, white frame, then asynchronous reset mid-frame
    do_reset("rst0");
    step(0, 0, 0, 1, 1);
    for (int x = 0; x < 10; x++) step(x, 5, 1, 0, 1);
    do_reset("rst_mid");
    for (int x = 0; x < 5; x++) step(x, 5, 1, 0, 1);

    // Bouncing box over 400 frames from a fresh reset
    do_reset("rst_box");
    for (int k = 1; k <= 400; k++) begin
      step(0, 0, 0, 1, 5);
      step(m_bx, m_by, 1, 0, 5);
      step(m_bx - 1, m_by, 1, 0, 5);
      step(m_bx + BOX_SIZE - 1, m_by + BOX_SIZE - 1, 1, 0, 5);
      step(m_bx + BOX_SIZE, m_by, 1, 0, 5);
      step(m_bx, m_by + BOX_SIZE, 1, 0, 5);
      if (k == 224) check("pin_by_224", 32'(m_by), 32'd448);
      if (k == 226) check("pin_by_226", 32'(m_by), 32'd446);
      if (k == 304) check("pin_bx_304", 32'(m_bx), 32'd608);
      if (k == 306) check("pin_bx_306", 32'(m_bx), 32'd606);
    end

    // Colour bars, including x beyond the active width
    step(0, 0, 0, 1, 2);
    for (int x = 0; x < 704; x++) step(x, 20, 1, 0, 2);
    step(0, 21, 0, 0, 2);

    // Checkerboard
    step(0, 0, 0, 1, 3);
    step(31, 0, 1, 0, 3);
    step(32, 0, 1, 0, 3);
    step(32, 32, 1, 0, 3);
    step(100, 70, 1, 0, 3);
    step(65, 31, 1, 0, 3);

    // Gray ramp
    step(0, 0, 0, 1, 4);
    step(4, 0, 1, 0, 4);
    step(1023, 0, 1, 0, 4);
    step(100, 0, 0, 0, 4);
    step(517, 3, 1, 0, 4);

    // Mode change without frame_start, then frame_start on an active pixel
    step(8, 0, 1, 0, 1);
    step(12, 0, 1, 1, 1);
    step(16, 0, 1, 0, 1);

    // Crosshair over ramp and reserved mode
    step(0, 0, 0, 1, 6);
    step(320, 10, 1, 0, 6);
    step(10, 240, 1, 0, 6);
    step(320, 240, 1, 0, 6);
    step(321, 241, 1, 0, 6);
    step(0, 0, 0, 1, 7);
    step(5, 5, 1, 0, 7);
    step(400, 300, 1, 0, 7);

    step(0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 7);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
